// File: rtl/hazard_scheduler.sv
// hazard_scheduler: in-order issue stage with an E/M/W write scoreboard, RAW stalls (no forwarding),
// a multi-cycle multiplier hold on E, and a saturating stall-cycle counter.
module hazard_scheduler #(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_ctrl,
    output logic        in_ready,
    output logic        ex_valid,
    output logic [31:0] ex_ctrl,
    output logic        mul_start,
    output logic        mul_busy,
    output logic        stall,
    output logic [15:0] stall_count
);
    typedef enum logic {RUN, MUL} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_ctrl_q, ex_ctrl_d;
    logic [6:0]  m_q, m_d, w_q, e_sb;
    logic        mul_start_q, mul_start_d, mul_busy_q, mul_busy_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [4:0]  rs, rt;
    logic        nop, reads_rs, reads_rt, is_mul, hazard, accept;

    // Scoreboard entry is {valid, wb_en, wb_reg}; register 0 is never blocked.
    function automatic logic blocks(input logic [6:0] sb, input logic [4:0] r);
        return sb[6] & sb[5] & (sb[4:0] == r) & (r != 5'd0);
    endfunction

    assign e_sb     = {ex_valid_q, ex_ctrl_q[5], ex_ctrl_q[4:0]};
    assign rs       = in_ctrl[26:22];
    assign rt       = in_ctrl[21:17];
    assign nop      = ~in_ctrl[5] & ~in_ctrl[7];
    assign reads_rs = ~nop;
    assign reads_rt = ~nop & (~in_ctrl[10] | in_ctrl[7]);
    assign is_mul   = in_ctrl[5] & ~in_ctrl[6] & in_ctrl[11];
    assign hazard   = (reads_rs & (blocks(e_sb, rs) | blocks(m_q, rs) | blocks(w_q, rs)))
                    | (reads_rt & (blocks(e_sb, rt) | blocks(m_q, rt) | blocks(w_q, rt)));
    assign in_ready = (state_q == RUN) & ~hazard;
    assign stall    = in_valid & ~in_ready;
    assign accept   = in_valid & in_ready;

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign mul_start   = mul_start_q;
    assign mul_busy    = mul_busy_q;
    assign stall_count = stall_count_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ex_valid_d    = ex_valid_q;
        ex_ctrl_d     = ex_ctrl_q;
        m_d           = e_sb;
        mul_start_d   = 1'b0;
        mul_busy_d    = mul_busy_q;
        stall_count_d = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
        if (state_q == RUN) begin
            ex_valid_d  = accept;
            ex_ctrl_d   = accept ? in_ctrl : 32'd0;
            mul_start_d = accept & is_mul;
            if (accept && is_mul && MUL_LATENCY > 1) begin
                state_d    = MUL;
                mul_busy_d = 1'b1;
                cnt_d      = 4'(MUL_LATENCY - 1);
            end
        end else begin
            // E is frozen on the multiply, so M receives bubbles while older writes drain.
            m_d   = 7'd0;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d    = RUN;
                mul_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            ex_valid_q    <= 1'b0;
            ex_ctrl_q     <= 32'd0;
            m_q           <= 7'd0;
            w_q           <= 7'd0;
            mul_start_q   <= 1'b0;
            mul_busy_q    <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ex_valid_q    <= ex_valid_d;
            ex_ctrl_q     <= ex_ctrl_d;
            m_q           <= m_d;
            w_q           <= m_q;
            mul_start_q   <= mul_start_d;
            mul_busy_q    <= mul_busy_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed and random issue streams checked cycle by cycle against a
// reference model that tracks, per register, the first cycle it becomes readable.
module tb_hazard_scheduler;
    localparam int ML = 4;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, ex_valid, mul_start, mul_busy, stall;
    logic [31:0] in_ctrl, ex_ctrl;
    logic [15:0] stall_count;
    int total = 0, bad = 0;
    int t = 0, mul_free = 0, sc = 0;
    int ready_at [32];
    logic        ev = 1'b0, ms = 1'b0;
    logic [31:0] ec = 32'd0;

    hazard_scheduler #(.MUL_LATENCY(ML)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ready(in_ready),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .mul_start(mul_start), .mul_busy(mul_busy),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int rs, input int rt, input int wb, input bit d,
                                        input bit c, input bit wr, input bit ws, input bit we);
        logic [31:0] w;
        w = 32'd0;
        w[26:22] = 5'(rs);
        w[21:17] = 5'(rt);
        w[16:12] = 5'(wb);
        w[11] = d;
        w[10] = c;
        w[7] = wr;
        w[6] = ws;
        w[5] = we;
        w[4:0] = 5'(wb);
        return w;
    endfunction

    function automatic bit ctrl_is_mul(input logic [31:0] c);
        return c[5] && !c[6] && c[11];
    endfunction

    // A register written by a word accepted in cycle a is readable from cycle a+L+3.
    function automatic bit model_ready(input logic [31:0] c);
        bit nop, hz;
        int rs, rt;
        nop = !c[5] && !c[7];
        rs = int'(c[26:22]);
        rt = int'(c[21:17]);
        hz = (!nop && rs != 0 && t < ready_at[rs])
          || (!nop && (!c[10] || c[7]) && rt != 0 && t < ready_at[rt]);
        return (t >= mul_free) && !hz;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] c);
        bit rdy;
        int len;
        rst = r;
        in_valid = v;
        in_ctrl = c;
        #2;
        rdy = model_ready(c);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("stall", 32'(stall), 32'(v && !rdy));
        chk("ex_valid", 32'(ex_valid), 32'(ev));
        chk("ex_ctrl", ex_ctrl, ec);
        chk("mul_start", 32'(mul_start), 32'(ms));
        chk("mul_busy", 32'(mul_busy), 32'(t < mul_free));
        chk("stall_count", 32'(stall_count), 32'(sc));
        @(posedge clk);
        #1;
        if (r) begin
            foreach (ready_at[i]) ready_at[i] = 0;
            mul_free = 0;
            ev = 1'b0;
            ec = 32'd0;
            ms = 1'b0;
            sc = 0;
        end else begin
            if (v && !rdy && sc < 65535) sc++;
            if (v && rdy) begin
                len = ctrl_is_mul(c) ? ML : 1;
                if (c[5] && c[4:0] != 5'd0) ready_at[c[4:0]] = t + len + 3;
                if (ctrl_is_mul(c)) mul_free = t + len;
                ev = 1'b1;
                ec = c;
                ms = ctrl_is_mul(c);
            end else begin
                ms = 1'b0;
                if (t >= mul_free) begin
                    ev = 1'b0;
                    ec = 32'd0;
                end
            end
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] w, add1, mulw, ld;
        foreach (ready_at[i]) ready_at[i] = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_ctrl = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        add1 = 32'h00443023;
        // random stream over r0..r3, then a two-cycle reset mid-stream
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            w[26:22] = 5'($urandom_range(0, 3));
            w[21:17] = 5'($urandom_range(0, 3));
            w[4:0] = 5'($urandom_range(0, 3));
            step(1'b0, ($urandom_range(0, 3) != 0), w);
        end
        step(1'b1, 1'b1, add1);
        step(1'b1, 1'b0, 32'd0);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_count", 32'(stall_count), 32'd0);
        idle(1);
        // independent back-to-back adds
        step(1'b0, 1'b1, add1);
        step(1'b0, 1'b1, enc(4, 5, 6, 0, 0, 0, 0, 1));
        idle(1);
        chk("indep_count", 32'(stall_count), 32'd0);
        idle(4);
        // RAW on r3
        step(1'b0, 1'b1, add1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, enc(3, 1, 7, 0, 0, 1, 0, 1));
        chk("raw_count", 32'(stall_count), 32'd3);
        idle(5);
        // multiply then independent add
        step(1'b1, 1'b0, 32'd0);
        mulw = enc(1, 2, 8, 1, 0, 0, 0, 1);
        step(1'b0, 1'b1, mulw);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, enc(4, 5, 6, 0, 0, 0, 0, 1));
        chk("mul_count", 32'(stall_count), 32'd3);
        idle(6);
        // load r9 then store reading r9
        step(1'b1, 1'b0, 32'd0);
        ld = enc(2, 0, 9, 0, 1, 0, 1, 1);
        step(1'b0, 1'b1, ld);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, enc(2, 9, 0, 0, 1, 1, 0, 0));
        chk("ldst_count", 32'(stall_count), 32'd3);
        idle(4);
        // write r0 then read r0: never a hazard
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, enc(1, 2, 0, 0, 0, 0, 0, 1));
        step(1'b0, 1'b1, enc(0, 0, 5, 0, 0, 0, 0, 1));
        idle(1);
        chk("r0_count", 32'(stall_count), 32'd0);
        idle(4);
        // saturation: self-dependent multiply chain stalls 6 of every 7 cycles
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 77000; i++) step(1'b0, 1'b1, enc(1, 1, 1, 1, 0, 0, 0, 1));
        chk("sat_count", 32'(stall_count), 32'hFFFF);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, enc(1, 1, 1, 1, 0, 0, 0, 1));
        chk("sat_hold", 32'(stall_count), 32'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
